// File: rtl/control_contador.sv
// Shared up-counter arbitrated round-robin between two requesters.
// Each job counts 0..L (L latched at grant), pulses done to its owner, then frees the counter.
module control_contador #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [1:0]   req,
  input  logic [N-1:0] len0,
  input  logic [N-1:0] len1,
  output logic [1:0]   grant,
  output logic [1:0]   done,
  output logic         busy,
  output logic [N-1:0] Q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic         ptr;
  logic         owner;
  logic [N-1:0] lim;
  logic         win_c;

  // Single requester wins outright; on a tie the one not served last wins.
  always_comb begin
    win_c = req[1];
    if (req == 2'b11) win_c = ~ptr;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      ptr   <= 1'b1;
      owner <= 1'b0;
      lim   <= '0;
      grant <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
      Q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 2'b00;
          Q    <= '0;
          if (req != 2'b00) begin
            state <= RUN;
            owner <= win_c;
            lim   <= win_c ? len1 : len0;
            grant <= win_c ? 2'b10 : 2'b01;
            busy  <= 1'b1;
          end else begin
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          // Owner withdrawing its request aborts the job silently.
          if (!req[owner]) begin
            state <= IDLE;
            ptr   <= owner;
            grant <= 2'b00;
            busy  <= 1'b0;
            Q     <= '0;
          end else if (Q == lim) begin
            state <= DONE;
            done  <= grant;
          end else begin
            Q <= Q + N'(1);
          end
        end

        DONE: begin
          state <= IDLE;
          ptr   <= owner;
          done  <= 2'b00;
          grant <= 2'b00;
          busy  <= 1'b0;
          Q     <= '0;
        end

        default: begin
          state <= IDLE;
          done  <= 2'b00;
          grant <= 2'b00;
          busy  <= 1'b0;
          Q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_contador.sv
// Self-checking bench for control_contador: directed vector table, corner-case
// sequences and randomized traffic against a job-level reference model.
module tb_control_contador;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic [1:0]   req;
  logic [N-1:0] len0, len1;
  logic [1:0]   grant, done;
  logic         busy;
  logic [N-1:0] Q;

  int total = 0;
  int bad   = 0;

  control_contador #(.N(N)) dut (
    .clk(clk), .clr(clr), .req(req), .len0(len0), .len1(len1),
    .grant(grant), .done(done), .busy(busy), .Q(Q)
  );

  always #5 clk = ~clk;

  // Reference: a job is "active" with elapsed cycles t since grant; Q tracks
  // min(t, L), done shows at t == L+1, and the job ends one cycle later.
  bit m_act, m_own, m_ptr;
  int m_l, m_t;

  function automatic void m_reset();
    m_act = 1'b0; m_ptr = 1'b1; m_t = 0; m_l = 0; m_own = 1'b0;
  endfunction

  function automatic void m_step(input logic [1:0] r, input int l0, input int l1);
    if (!m_act) begin
      if (r != 2'b00) begin
        m_own = (r == 2'b11) ? !m_ptr : r[1];
        m_l   = m_own ? l1 : l0;
        m_t   = 0;
        m_act = 1'b1;
      end
    end else if (m_t == m_l + 1) begin
      m_act = 1'b0; m_ptr = m_own;
    end else if (!r[m_own]) begin
      m_act = 1'b0; m_ptr = m_own;
    end else begin
      m_t++;
    end
  endfunction

  function automatic logic [1:0] m_onehot();
    return m_own ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [8:0] m_expect();
    logic [1:0]   g, d;
    logic [N-1:0] q;
    g = m_act ? m_onehot() : 2'b00;
    d = (m_act && m_t == m_l + 1) ? m_onehot() : 2'b00;
    q = m_act ? N'((m_t > m_l) ? m_l : m_t) : N'(0);
    return {g, d, m_act, q};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, advance model, compare {grant,done,busy,Q}.
  task automatic cycle(input logic [1:0] r, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c);
    req = r; len0 = a; len1 = b; clr = c;
    @(posedge clk);
    #1;
    if (c) m_reset();
    else   m_step(r, int'(a), int'(b));
    chk("model", 32'({grant, done, busy, Q}), 32'(m_expect()));
  endtask

  typedef struct {
    logic [1:0]   req;
    logic [N-1:0] l0, l1;
    logic [1:0]   eg;
    logic [N-1:0] eq;
    logic [1:0]   ed;
    logic         eb;
  } vec_t;

  vec_t tbl[19];
  logic [1:0] cr;

  initial begin
    // L=5 on requester 0: Q 0..5, done, back to idle
    for (int i = 0; i < 6; i++) tbl[i] = '{2'b01, 4'd5, 4'd0, 2'b01, N'(i), 2'b00, 1'b1};
    tbl[6]  = '{2'b01, 4'd5, 4'd0, 2'b01, 4'd5, 2'b01, 1'b1};
    tbl[7]  = '{2'b00, 4'd5, 4'd0, 2'b00, 4'd0, 2'b00, 1'b0};
    tbl[8]  = '{2'b00, 4'd5, 4'd0, 2'b00, 4'd0, 2'b00, 1'b0};
    // L=0 on requester 1: done right after grant
    tbl[9]  = '{2'b10, 4'd3, 4'd0, 2'b10, 4'd0, 2'b00, 1'b1};
    tbl[10] = '{2'b10, 4'd3, 4'd0, 2'b10, 4'd0, 2'b10, 1'b1};
    tbl[11] = '{2'b00, 4'd3, 4'd0, 2'b00, 4'd0, 2'b00, 1'b0};
    // len changes after grant ignored; non-owner request held and then served
    tbl[12] = '{2'b01, 4'd2, 4'd0, 2'b01, 4'd0, 2'b00, 1'b1};
    tbl[13] = '{2'b11, 4'd9, 4'd7, 2'b01, 4'd1, 2'b00, 1'b1};
    tbl[14] = '{2'b11, 4'd9, 4'd7, 2'b01, 4'd2, 2'b00, 1'b1};
    tbl[15] = '{2'b11, 4'd9, 4'd7, 2'b01, 4'd2, 2'b01, 1'b1};
    tbl[16] = '{2'b10, 4'd9, 4'd7, 2'b00, 4'd0, 2'b00, 1'b0};
    tbl[17] = '{2'b10, 4'd9, 4'd7, 2'b10, 4'd0, 2'b00, 1'b1};
    tbl[18] = '{2'b00, 4'd9, 4'd7, 2'b00, 4'd0, 2'b00, 1'b0};

    req = 2'b00; len0 = '0; len1 = '0; clr = 1'b1;
    m_reset();
    #2;
    chk("reset_async", 32'({grant, done, busy, Q}), 32'(0));
    cycle(2'b00, 4'd0, 4'd0, 1'b1);
    cycle(2'b00, 4'd0, 4'd0, 1'b0);
    chk("reset_idle", 32'({grant, done, busy, Q}), 32'(0));

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].req, tbl[i].l0, tbl[i].l1, 1'b0);
      chk($sformatf("vec%0d", i), 32'({grant, done, busy, Q}),
          32'({tbl[i].eg, tbl[i].ed, tbl[i].eb, tbl[i].eq}));
    end

    // Tie after reset: requester 0 first, one idle cycle, then requester 1
    cycle(2'b00, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(2'b11, 4'd2, 4'd2, 1'b0);
      case (i)
        0: chk("tie_grant0", 32'(grant), 32'(2'b01));
        3: chk("tie_done0", 32'(done), 32'(2'b01));
        4: chk("tie_gap", 32'({grant, busy}), 32'(0));
        5: chk("tie_grant1", 32'(grant), 32'(2'b10));
        8: chk("tie_done1", 32'(done), 32'(2'b10));
        default: ;
      endcase
    end
    cycle(2'b00, 4'd2, 4'd2, 1'b0);

    // Full-range count: L=15 ends at 15 without wrapping
    for (int i = 0; i < 18; i++) begin
      cycle((i < 17) ? 2'b01 : 2'b00, 4'd15, 4'd0, 1'b0);
      if (i == 15) chk("max_q15", 32'(Q), 32'(15));
      if (i == 16) chk("max_done", 32'({done, Q}), 32'({2'b01, 4'd15}));
      if (i == 17) chk("max_idle", 32'({grant, Q}), 32'(0));
    end
    cycle(2'b00, 4'd0, 4'd0, 1'b0);

    // Abort: req0 dropped at Q=2 while req1 held
    for (int i = 0; i < 10; i++) begin
      cycle((i == 0) ? 2'b01 : (i < 3) ? 2'b11 : (i < 9) ? 2'b10 : 2'b00, 4'd9, 4'd3, 1'b0);
      if (i == 2) chk("abort_q2", 32'(Q), 32'(2));
      if (i == 3) chk("abort_idle", 32'({grant, done, busy}), 32'(0));
      if (i == 4) chk("abort_next", 32'(grant), 32'(2'b10));
      if (i == 8) chk("abort_done1", 32'(done), 32'(2'b10));
    end

    // Asynchronous clear mid-run at Q=3
    for (int i = 0; i < 4; i++) cycle(2'b01, 4'd9, 4'd0, 1'b0);
    chk("clr_pre_q3", 32'(Q), 32'(3));
    #3 clr = 1'b1;
    #1;
    chk("clr_async", 32'({grant, done, busy, Q}), 32'(0));
    m_reset();
    cycle(2'b01, 4'd9, 4'd0, 1'b1);
    cycle(2'b11, 4'd2, 4'd2, 1'b0);
    chk("clr_tie0", 32'(grant), 32'(2'b01));
    cycle(2'b00, 4'd2, 4'd2, 1'b0);

    // Randomized traffic with sticky requests and changing lengths
    cr = 2'b00;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) cr[0] = ~cr[0];
      if ($urandom_range(0, 5) == 0) cr[1] = ~cr[1];
      cycle(cr, N'($urandom_range(0, 15)), N'($urandom_range(0, 15)),
            ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
